wb_test_target: RTL and testbench
=================================

// Module: wb_test_target
// PURPOSE
//  Wishbone classic slave that answers the test-sequencer master. Maps a word-addressed program
//  memory and a register bank into one 16-bit data space, with a programmable number of wait states.
//  A host load port fills program memory. A device-side port lets models update registers, so WAIT
//  instructions can complete. Access and error counters support bench checks.
// PARAMETERS
//  ADDRESS_WIDTH  24         wbAdrI width
//  PROGMEM_START  'h10000    word address of progmem[0]
//  PROGMEM_WORDS  256        progmem depth (16-bit words), power of 2
//  REGMEM_START   'h00000    word address of reg[0]
//  REG_COUNT      16         register count, power of 2, <=256
//  WAIT_STATES    1          cycles between request capture and ack (0..255)
//  UNMAPPED_DATA  16'hDEAD   read data returned for unmapped addresses
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  wbAdrI      in   AW     Wishbone address (word)
//  wbDatI      in   16     Wishbone write data
//  wbDatO      out  16     Wishbone read data
//  wbCycI      in   1      Wishbone cycle
//  wbStbI      in   1      Wishbone strobe
//  wbWeI       in   1      Wishbone write enable
//  wbAckO      out  1      Wishbone ack, registered, one-cycle pulse
//  loadEn      in   1      host write strobe into progmem
//  loadAddr    in   log2(PROGMEM_WORDS)  progmem index
//  loadData    in   16     progmem write data
//  extWe       in   1      device-side register write strobe
//  extIdx      in   log2(REG_COUNT)  register index for extWe / regObsDat
//  extDat      in   16     device-side write data
//  regObsDat   out  16     combinational read of reg[extIdx]
//  accessCount out  16     completed (acked) transfers, saturates at 16'hFFFF
//  errCount    out  16     acked transfers that were unmapped reads/writes or progmem writes; saturates
// BEHAVIOUR
//  Reset: wbAckO=0, wbDatO=0, counters=0, all registers=0, FSM=IDLE. Progmem contents are not reset.
//  FSM IDLE:
//   - wbCycI&wbStbI at an edge captures adr/we/dat.
//   - Goes to WAIT with waitCnt=WAIT_STATES-1, or to ACK if WAIT_STATES==0.
//  FSM WAIT:
//   - !wbCycI -> IDLE: abort, no ack, no write, no counter change.
//   - waitCnt==0 -> ACK, else waitCnt--.
//  FSM ACK:
//   - wbAckO=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  Latency: ack is high in cycle WAIT_STATES+1 after the capture edge.
//  Back-to-back: stb still high in ACK is not a new request. Sampling resumes in IDLE.
//   Minimum period is WAIT_STATES+2 cycles per transfer.
//  On the edge entering ACK:
//   - wbDatO loaded (reads only); write committed; accessCount++ and errCount++ as applicable.
//   - wbDatO holds its last value otherwise.
//  Decode (on captured adr):
//   - REG: REGMEM_START <= adr < +REG_COUNT -> reg[adr-START], read/write.
//   - PROG: PROGMEM_START <= adr < +PROGMEM_WORDS -> read-only; write ignored, acked, errCount++.
//   - Other addresses: read returns UNMAPPED_DATA; write ignored; both acked, errCount++.
//   - Address compare is full ADDRESS_WIDTH, no aliasing.
//  Simultaneous events:
//   - Wishbone write and extWe to same reg at same edge: Wishbone value wins.
//   - loadEn and Wishbone read of same progmem word at same edge: read returns old word.
//   - extWe/loadEn are accepted in every state, including during reset deassertion cycles.
//  Mid-transfer rst: FSM -> IDLE, ack suppressed, pending write dropped.
// TESTING
//  WS=1: read reg 3 (=16'h0042 via extWe) -> wbAckO high 2 cycles after capture, wbDatO=16'h0042, accessCount=1.
//  Write 16'h1234 to adr 5 -> ack, regObsDat(extIdx=5)=16'h1234; errCount=0.
//  loadEn fills progmem[0..2]={1,7,9}; master reads 'h10000..'h10002 back-to-back -> 1,7,9, one ack per 3 cycles.
//  Read 'h20000 -> wbDatO=16'hDEAD, errCount=1. Write 'h10000 -> progmem unchanged, errCount=2.
//  Drop wbCycI in WAIT (WS=4) -> no ack, counters unchanged. rst in WAIT -> wbAckO=0, wbDatO=0.
//  Same-edge Wishbone write 16'hAAAA and extWe 16'h5555 to reg 2 -> reg 2 = 16'hAAAA.

Source files
------------

// File: rtl/wb_test_target.sv
// Wishbone classic slave for the test sequencer: register bank plus read-only program
// memory in one 16-bit word space, with fixed wait states and access/error counters.
module wb_test_target #(
    parameter int unsigned ADDRESS_WIDTH = 24,
    parameter int unsigned PROGMEM_START = 'h10000,
    parameter int unsigned PROGMEM_WORDS = 256,
    parameter int unsigned REGMEM_START  = 'h00000,
    parameter int unsigned REG_COUNT     = 16,
    parameter int unsigned WAIT_STATES   = 1,
    parameter logic [15:0] UNMAPPED_DATA = 16'hDEAD,
    localparam int unsigned PIW = $clog2(PROGMEM_WORDS),
    localparam int unsigned RIW = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] wbAdrI,
    input  logic [15:0]              wbDatI,
    output logic [15:0]              wbDatO,
    input  logic                     wbCycI,
    input  logic                     wbStbI,
    input  logic                     wbWeI,
    output logic                     wbAckO,
    input  logic                     loadEn,
    input  logic [PIW-1:0]           loadAddr,
    input  logic [15:0]              loadData,
    input  logic                     extWe,
    input  logic [RIW-1:0]           extIdx,
    input  logic [15:0]              extDat,
    output logic [15:0]              regObsDat,
    output logic [15:0]              accessCount,
    output logic [15:0]              errCount
);

    // state   | meaning
    // ST_IDLE | waiting for cyc&stb; request captured on the edge it is seen
    // ST_WAIT | counting wait states down; dropping cyc aborts the transfer
    // ST_ACK  | ack asserted for this single cycle, then back to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] REG_BASE  = ADDRESS_WIDTH'(REGMEM_START);
    localparam logic [ADDRESS_WIDTH-1:0] REG_SPAN  = ADDRESS_WIDTH'(REG_COUNT);
    localparam logic [ADDRESS_WIDTH-1:0] PROG_BASE = ADDRESS_WIDTH'(PROGMEM_START);
    localparam logic [ADDRESS_WIDTH-1:0] PROG_SPAN = ADDRESS_WIDTH'(PROGMEM_WORDS);

    state_t                   state_q, state_d;
    logic [7:0]               wait_q, wait_d;
    logic [ADDRESS_WIDTH-1:0] adr_q;
    logic                     we_q;
    logic [15:0]              dat_q;
    logic                     capture;
    logic                     commit;

    logic [15:0]              regs_q [REG_COUNT];
    logic [15:0]              progmem_q [PROGMEM_WORDS];
    logic [15:0]              dat_o_q;
    logic [15:0]              acc_cnt_q;
    logic [15:0]              err_cnt_q;

    logic [ADDRESS_WIDTH-1:0] req_adr;
    logic                     req_we;
    logic [15:0]              req_dat;
    logic [ADDRESS_WIDTH-1:0] off_reg;
    logic [ADDRESS_WIDTH-1:0] off_prog;
    logic                     reg_hit;
    logic                     prog_hit;
    logic [RIW-1:0]           reg_idx;
    logic [PIW-1:0]           prog_idx;
    logic [15:0]              rd_data;
    logic                     err_evt;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbCycI && wbStbI) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = 8'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!wbCycI) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 8'd0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (capture) begin
                adr_q <= wbAdrI;
                we_q  <= wbWeI;
                dat_q <= wbDatI;
            end
        end
    end

    // With zero wait states the commit happens on the capture edge, so decode the live bus.
    assign req_adr = (state_q == ST_IDLE) ? wbAdrI : adr_q;
    assign req_we  = (state_q == ST_IDLE) ? wbWeI  : we_q;
    assign req_dat = (state_q == ST_IDLE) ? wbDatI : dat_q;

    assign off_reg  = req_adr - REG_BASE;
    assign off_prog = req_adr - PROG_BASE;
    assign reg_hit  = (req_adr >= REG_BASE)  && (off_reg  < REG_SPAN);
    assign prog_hit = (req_adr >= PROG_BASE) && (off_prog < PROG_SPAN);
    assign reg_idx  = RIW'(off_reg);
    assign prog_idx = PIW'(off_prog);

    always_comb begin
        rd_data = UNMAPPED_DATA;
        if (reg_hit) begin
            rd_data = regs_q[reg_idx];
        end else if (prog_hit) begin
            rd_data = progmem_q[prog_idx];
        end
    end

    assign err_evt = !reg_hit && (req_we || !prog_hit);

    // Bus write is scheduled after the device-side write so it wins on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            if (extWe) begin
                regs_q[extIdx] <= extDat;
            end
            if (commit && req_we && reg_hit) begin
                regs_q[reg_idx] <= req_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loadEn) begin
            progmem_q[loadAddr] <= loadData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_o_q   <= 16'h0000;
            acc_cnt_q <= 16'h0000;
            err_cnt_q <= 16'h0000;
        end else if (commit) begin
            if (!req_we) begin
                dat_o_q <= rd_data;
            end
            if (acc_cnt_q != 16'hFFFF) begin
                acc_cnt_q <= acc_cnt_q + 16'd1;
            end
            if (err_evt && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign wbAckO      = (state_q == ST_ACK);
    assign wbDatO      = dat_o_q;
    assign accessCount = acc_cnt_q;
    assign errCount    = err_cnt_q;
    assign regObsDat   = regs_q[extIdx];

endmodule

// File: tb/tb_wb_test_target.sv
// Directed bench for wb_test_target (WAIT_STATES=1): vector table of single transfers
// plus hand sequences for back-to-back, collisions, abort and mid-transfer reset.
module tb_wb_test_target;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] wbAdrI;
    logic [15:0] wbDatI;
    logic [15:0] wbDatO;
    logic        wbCycI, wbStbI, wbWeI, wbAckO;
    logic        loadEn;
    logic [7:0]  loadAddr;
    logic [15:0] loadData;
    logic        extWe;
    logic [3:0]  extIdx;
    logic [15:0] extDat;
    logic [15:0] regObsDat, accessCount, errCount;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no++;

    wb_test_target #(.ADDRESS_WIDTH(24), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .wbAdrI(wbAdrI), .wbDatI(wbDatI), .wbDatO(wbDatO),
        .wbCycI(wbCycI), .wbStbI(wbStbI), .wbWeI(wbWeI), .wbAckO(wbAckO),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
        .extWe(extWe), .extIdx(extIdx), .extDat(extDat),
        .regObsDat(regObsDat), .accessCount(accessCount), .errCount(errCount)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [23:0] adr;
        logic [15:0] dat;
        logic [15:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one request and returns the number of edges (capture edge included) until ack.
    task automatic wb_xfer(input logic we, input logic [23:0] adr, input logic [15:0] dat,
                           output int lat);
        wbCycI = 1'b1; wbStbI = 1'b1; wbWeI = we; wbAdrI = adr; wbDatI = dat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!wbAckO && lat < 20);
        wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    endtask

    task automatic obs(input logic [3:0] idx, input string name, input logic [15:0] exp);
        extIdx = idx;
        #1;
        check(name, regObsDat, exp);
    endtask

    initial begin
        int          lat;
        int          ack_edge[3];
        logic [15:0] last_rd;
        logic [15:0] exp_acc;
        logic [15:0] exp_err;

        rst = 1'b1;
        wbAdrI = '0; wbDatI = '0; wbCycI = 0; wbStbI = 0; wbWeI = 0;
        loadEn = 0; loadAddr = '0; loadData = '0;
        extWe = 0; extIdx = '0; extDat = '0;
        tick(); tick();
        check("reset_ack", wbAckO, 0);
        check("reset_dat", wbDatO, 0);
        check("reset_acc", accessCount, 0);
        check("reset_err", errCount, 0);
        obs(4'd3, "reset_reg3", 16'h0000);
        rst = 1'b0;
        tick();

        extWe = 1; extIdx = 4'd3; extDat = 16'h0042;
        tick();
        extWe = 0;
        obs(4'd3, "extwe_reg3", 16'h0042);

        loadEn = 1;
        loadAddr = 8'd0;   loadData = 16'd1; tick();
        loadAddr = 8'd1;   loadData = 16'd7; tick();
        loadAddr = 8'd2;   loadData = 16'd9; tick();
        loadAddr = 8'd255; loadData = 16'h55AA; tick();
        loadEn = 0;

        vecs[0]  = '{"rd_reg3",        1'b0, 24'h000003, 16'h0000, 16'h0042, 1'b0};
        vecs[1]  = '{"wr_reg5",        1'b1, 24'h000005, 16'h1234, 16'h1234, 1'b0};
        vecs[2]  = '{"rd_reg5",        1'b0, 24'h000005, 16'h0000, 16'h1234, 1'b0};
        vecs[3]  = '{"rd_prog0",       1'b0, 24'h010000, 16'h0000, 16'h0001, 1'b0};
        vecs[4]  = '{"rd_prog1",       1'b0, 24'h010001, 16'h0000, 16'h0007, 1'b0};
        vecs[5]  = '{"rd_prog2",       1'b0, 24'h010002, 16'h0000, 16'h0009, 1'b0};
        vecs[6]  = '{"rd_unmapped",    1'b0, 24'h020000, 16'h0000, 16'hDEAD, 1'b1};
        vecs[7]  = '{"wr_prog0",       1'b1, 24'h010000, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[8]  = '{"rd_prog0_kept",  1'b0, 24'h010000, 16'h0000, 16'h0001, 1'b0};
        vecs[9]  = '{"wr_reg15",       1'b1, 24'h00000F, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[10] = '{"rd_reg15",       1'b0, 24'h00000F, 16'h0000, 16'hBEEF, 1'b0};
        vecs[11] = '{"rd_past_regs",   1'b0, 24'h000010, 16'h0000, 16'hDEAD, 1'b1};
        vecs[12] = '{"rd_prog_last",   1'b0, 24'h0100FF, 16'h0000, 16'h55AA, 1'b0};
        vecs[13] = '{"rd_past_prog",   1'b0, 24'h010100, 16'h0000, 16'hDEAD, 1'b1};
        vecs[14] = '{"rd_no_alias",    1'b0, 24'h100003, 16'h0000, 16'hDEAD, 1'b1};
        vecs[15] = '{"rd_top",         1'b0, 24'hFFFFFF, 16'h0000, 16'hDEAD, 1'b1};

        last_rd = 16'h0000;
        exp_acc = 16'd0;
        exp_err = 16'd0;
        for (int i = 0; i < 16; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, lat);
            exp_acc = exp_acc + 16'd1;
            if (vecs[i].err) exp_err = exp_err + 16'd1;
            if (!vecs[i].we) last_rd = vecs[i].exp;
            check({vecs[i].name, "_lat"}, lat, 2);
            check({vecs[i].name, "_dat"}, wbDatO, last_rd);
            check({vecs[i].name, "_acc"}, accessCount, exp_acc);
            check({vecs[i].name, "_err"}, errCount, exp_err);
            if (vecs[i].we && vecs[i].adr < 24'h000010) begin
                obs(vecs[i].adr[3:0], {vecs[i].name, "_obs"}, vecs[i].exp);
            end
            tick();
            check({vecs[i].name, "_ack_pulse"}, wbAckO, 0);
        end

        // back-to-back reads with strobe held high: one ack every 3 cycles
        wbCycI = 1; wbStbI = 1; wbWeI = 0;
        for (int i = 0; i < 3; i++) begin
            wbAdrI = 24'h010000 + 24'(i);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!wbAckO && lat < 10);
            ack_edge[i] = edge_no;
            check("b2b_ack", wbAckO, 1);
            check("b2b_dat", wbDatO, (i == 0) ? 16'd1 : (i == 1) ? 16'd7 : 16'd9);
        end
        wbCycI = 0; wbStbI = 0;
        exp_acc = exp_acc + 16'd3;
        last_rd = 16'd9;
        check("b2b_period_a", ack_edge[1] - ack_edge[0], 3);
        check("b2b_period_b", ack_edge[2] - ack_edge[1], 3);
        check("b2b_acc", accessCount, exp_acc);
        tick();

        // loadEn on the same edge as the progmem read: old word returned
        wbCycI = 1; wbStbI = 1; wbWeI = 0; wbAdrI = 24'h010001;
        tick();
        loadEn = 1; loadAddr = 8'd1; loadData = 16'h0077;
        tick();
        loadEn = 0; wbCycI = 0; wbStbI = 0;
        check("load_coll_ack", wbAckO, 1);
        check("load_coll_old", wbDatO, 16'h0007);
        tick();
        wb_xfer(1'b0, 24'h010001, 16'h0000, lat);
        check("load_coll_new", wbDatO, 16'h0077);
        exp_acc = exp_acc + 16'd2;
        last_rd = 16'h0077;
        tick();

        // bus write and extWe to reg 2 on the same edge: bus value wins
        wbCycI = 1; wbStbI = 1; wbWeI = 1; wbAdrI = 24'h000002; wbDatI = 16'hAAAA;
        tick();
        extWe = 1; extIdx = 4'd2; extDat = 16'h5555;
        tick();
        extWe = 0; wbCycI = 0; wbStbI = 0; wbWeI = 0;
        check("coll_ack", wbAckO, 1);
        obs(4'd2, "coll_reg2", 16'hAAAA);
        exp_acc = exp_acc + 16'd1;
        tick();

        // cyc dropped in WAIT: no ack, no write, counters untouched
        wbCycI = 1; wbStbI = 1; wbWeI = 1; wbAdrI = 24'h000006; wbDatI = 16'h9999;
        tick();
        wbCycI = 0; wbStbI = 0; wbWeI = 0;
        tick();
        check("abort_ack0", wbAckO, 0);
        tick();
        check("abort_ack1", wbAckO, 0);
        check("abort_acc", accessCount, exp_acc);
        check("abort_err", errCount, exp_err);
        check("abort_dat", wbDatO, last_rd);
        obs(4'd6, "abort_reg6", 16'h0000);

        // reset while in WAIT: pending write dropped, everything cleared
        wbCycI = 1; wbStbI = 1; wbWeI = 1; wbAdrI = 24'h000007; wbDatI = 16'h7777;
        tick();
        rst = 1;
        tick();
        check("rst_wait_ack", wbAckO, 0);
        check("rst_wait_dat", wbDatO, 0);
        check("rst_wait_acc", accessCount, 0);
        check("rst_wait_err", errCount, 0);
        wbCycI = 0; wbStbI = 0; wbWeI = 0;
        rst = 0;
        tick();
        check("rst_after_ack", wbAckO, 0);
        obs(4'd7, "rst_reg7", 16'h0000);
        obs(4'd3, "rst_reg3", 16'h0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
